sprite_blitter: RTL and testbench

//  Parametrised sprite renderer for the VGA pipeline. Places one animated sprite at a

---
 rtl/sprite_blitter.sv | 218 +++++++++++++++++++++
 tb/tb_sprite_blitter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// -----------------------------------------------------------------------------
// sprite_blitter
//
// Renders one animated sprite into the VGA pixel stream. The sprite sits at a
// runtime top-left corner, can be magnified by a power of two, steps through
// several animation frames stored back-to-back in an external synchronous ROM,
// and treats one palette index as transparent. For every pixel the block
// reports whether an opaque sprite texel covers it and which palette index.
//
// Pipeline (fixed latency, no stalls):
//   stage 0 (comb)  box test and texel coordinate math on DrawX/DrawY
//   stage 1 (reg)   ROM address + visibility flag
//   stage 2 (reg)   visibility delayed while the ROM returns its data
//   stage 3 (reg)   transparency test, final pix_hit / pix_index
//
// Ports
//   vga_clk      pixel clock, everything on the rising edge
//   reset_n      asynchronous reset, active low
//   frame_start  one-cycle pulse at the start of each VGA frame
//   DrawX/DrawY  current pixel column / row
//   blank        1 while in the visible region
//   pos_x/pos_y  sprite top-left corner, captured on frame_start
//   sprite_en    sprite visible, captured on frame_start
//   anim_en      animation counters advance when 1
//   anim_restart one-cycle pulse returning animation to frame 0
//   rom_address  registered sprite ROM read address
//   rom_q        ROM data, valid one cycle after rom_address
//   pix_hit      opaque sprite pixel for the pixel presented 3 edges earlier
//   pix_index    palette index for that pixel, 0 when pix_hit is 0
//   anim_frame   current animation frame
//   anim_done    one-shot mode: last frame reached (always 0 when looping)
// -----------------------------------------------------------------------------
module sprite_blitter #(
    parameter int SPRITE_W    = 32,
    parameter int SPRITE_H    = 32,
    parameter int NUM_FRAMES  = 8,
    parameter int IDX_BITS    = 2,
    parameter int SCALE_SHIFT = 0,
    parameter int FRAME_DIV   = 6,
    parameter int ONE_SHOT    = 0,
    parameter int TRANSP_IDX  = 0,
    parameter int ADDR_W      = $clog2(SPRITE_W*SPRITE_H*NUM_FRAMES),
    localparam int FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                vga_clk,
    input  logic                reset_n,
    input  logic                frame_start,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic                blank,
    input  logic [9:0]          pos_x,
    input  logic [9:0]          pos_y,
    input  logic                sprite_en,
    input  logic                anim_en,
    input  logic                anim_restart,
    output logic [ADDR_W-1:0]   rom_address,
    input  logic [IDX_BITS-1:0] rom_q,
    output logic                pix_hit,
    output logic [IDX_BITS-1:0] pix_index,
    output logic [FRAME_W-1:0]  anim_frame,
    output logic                anim_done
);

    localparam int BOX_W = SPRITE_W << SCALE_SHIFT;
    localparam int BOX_H = SPRITE_H << SCALE_SHIFT;
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    // Per-frame shadow copies of the placement inputs
    logic [9:0]          posX_q;
    logic [9:0]          posY_q;
    logic                spriteEn_q;

    // Animation state
    logic [DIV_W-1:0]    divCnt_q,    divCnt_d;
    logic [FRAME_W-1:0]  animFrame_q, animFrame_d;
    logic                animDone_q,  animDone_d;

    // Stage 0 combinational results
    logic [10:0]         drawX11, drawY11;
    logic [10:0]         posX11,  posY11;
    logic [10:0]         boxEndX, boxEndY;
    logic [10:0]         dx, dy;
    logic [10:0]         dxScaled, dyScaled;
    logic                inBox;
    logic                hit1_d;
    logic [ADDR_W-1:0]   romAddr_d;

    // Pipeline registers
    logic [ADDR_W-1:0]   romAddr_q;
    logic                hit1_q;
    logic                hit2_q;
    logic                pixHit_q,   pixHit_d;
    logic [IDX_BITS-1:0] pixIndex_q, pixIndex_d;

    // Position and enable are only sampled at frame start so a sprite that
    // moves mid-frame never tears across the frame.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            posX_q     <= '0;
            posY_q     <= '0;
            spriteEn_q <= 1'b0;
        end else if (frame_start) begin
            posX_q     <= pos_x;
            posY_q     <= pos_y;
            spriteEn_q <= sprite_en;
        end
    end

    // Animation next-state. A restart pulse overrides everything, including a
    // coincident frame_start. On the last frame a looping sprite wraps to 0,
    // while a one-shot sprite parks there and raises done; done also rises on
    // the step that lands on the last frame.
    always_comb begin
        divCnt_d    = divCnt_q;
        animFrame_d = animFrame_q;
        animDone_d  = animDone_q;
        if (anim_restart) begin
            divCnt_d    = '0;
            animFrame_d = '0;
            animDone_d  = 1'b0;
        end else if (frame_start && anim_en) begin
            if (divCnt_q == DIV_W'(FRAME_DIV - 1)) begin
                divCnt_d = '0;
                if (animFrame_q == FRAME_W'(NUM_FRAMES - 1)) begin
                    if (ONE_SHOT != 0) begin
                        animDone_d = 1'b1;
                    end else begin
                        animFrame_d = '0;
                    end
                end else begin
                    animFrame_d = animFrame_q + 1'b1;
                    if ((ONE_SHOT != 0) && (animFrame_q == FRAME_W'(NUM_FRAMES - 2))) begin
                        animDone_d = 1'b1;
                    end
                end
            end else begin
                divCnt_d = divCnt_q + 1'b1;
            end
        end
    end

    // Animation state register
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            divCnt_q    <= '0;
            animFrame_q <= '0;
            animDone_q  <= 1'b0;
        end else begin
            divCnt_q    <= divCnt_d;
            animFrame_q <= animFrame_d;
            animDone_q  <= animDone_d;
        end
    end

    // Stage 0: the box test uses 11-bit sums so a sprite near the right or
    // bottom edge is clipped instead of wrapping around to column/row 0.
    // Inside the box the scaled offsets are always below the sprite size, so
    // the address never spills into a neighbouring frame.
    always_comb begin
        drawX11   = {1'b0, DrawX};
        drawY11   = {1'b0, DrawY};
        posX11    = {1'b0, posX_q};
        posY11    = {1'b0, posY_q};
        boxEndX   = posX11 + 11'(BOX_W);
        boxEndY   = posY11 + 11'(BOX_H);
        dx        = drawX11 - posX11;
        dy        = drawY11 - posY11;
        dxScaled  = dx >> SCALE_SHIFT;
        dyScaled  = dy >> SCALE_SHIFT;
        inBox     = (drawX11 >= posX11) && (drawX11 < boxEndX) &&
                    (drawY11 >= posY11) && (drawY11 < boxEndY);
        hit1_d    = inBox && blank && spriteEn_q;
        romAddr_d = ADDR_W'(animFrame_q) * ADDR_W'(SPRITE_W * SPRITE_H) +
                    ADDR_W'(dyScaled) * ADDR_W'(SPRITE_W) +
                    ADDR_W'(dxScaled);
    end

    // Stage 1/2: the address only moves for covered pixels, which keeps the
    // ROM bus quiet outside the sprite.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            romAddr_q <= '0;
            hit1_q    <= 1'b0;
            hit2_q    <= 1'b0;
        end else begin
            hit1_q <= hit1_d;
            hit2_q <= hit1_q;
            if (hit1_d) begin
                romAddr_q <= romAddr_d;
            end
        end
    end

    // Stage 3 decision: transparent texels drop out and the index is zeroed
    // so the mixer can OR layers without further masking.
    always_comb begin
        pixHit_d   = hit2_q && (rom_q != IDX_BITS'(TRANSP_IDX));
        pixIndex_d = pixHit_d ? rom_q : '0;
    end

    // Stage 3 register
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pixHit_q   <= 1'b0;
            pixIndex_q <= '0;
        end else begin
            pixHit_q   <= pixHit_d;
            pixIndex_q <= pixIndex_d;
        end
    end

    assign rom_address = romAddr_q;
    assign pix_hit     = pixHit_q;
    assign pix_index   = pixIndex_q;
    assign anim_frame  = animFrame_q;
    assign anim_done   = animDone_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// -----------------------------------------------------------------------------
// tb_sprite_blitter
//
// Two blitters share one stimulus stream: dut0 uses the default parameters
// (1x scale, looping animation), dut1 uses 2x scale and one-shot animation.
// A behavioural model recomputes every pixel from the sprite placement rules
// and the ROM image; animation state is derived from a count of enabled
// frame_start pulses.
// -----------------------------------------------------------------------------
module tb_sprite_blitter;

   logic       vga_clk = 1'b0;
   logic       reset_n;
   logic       frame_start;
   logic [9:0] DrawX, DrawY;
   logic       blank;
   logic [9:0] pos_x, pos_y;
   logic       sprite_en, anim_en, anim_restart;

   logic [12:0] romAddr0, romAddr1;
   logic [1:0]  romQ0, romQ1;
   logic        pixHit0, pixHit1;
   logic [1:0]  pixIndex0, pixIndex1;
   logic [2:0]  animFrame0, animFrame1;
   logic        animDone0, animDone1;

   logic [1:0]  romMem [0:8191];

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int mPx, mPy, ticks;
   bit mEn;

   // Free-running pixel clock
   always #5 vga_clk = ~vga_clk;

   // Synchronous sprite ROMs, one read port per DUT
   always @(posedge vga_clk) begin
      romQ0 <= romMem[romAddr0];
      romQ1 <= romMem[romAddr1];
   end

   sprite_blitter dut0 (
      .vga_clk(vga_clk), .reset_n(reset_n), .frame_start(frame_start),
      .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .pos_x(pos_x), .pos_y(pos_y), .sprite_en(sprite_en),
      .anim_en(anim_en), .anim_restart(anim_restart),
      .rom_address(romAddr0), .rom_q(romQ0),
      .pix_hit(pixHit0), .pix_index(pixIndex0),
      .anim_frame(animFrame0), .anim_done(animDone0)
   );

   sprite_blitter #(.SCALE_SHIFT(1), .ONE_SHOT(1)) dut1 (
      .vga_clk(vga_clk), .reset_n(reset_n), .frame_start(frame_start),
      .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .pos_x(pos_x), .pos_y(pos_y), .sprite_en(sprite_en),
      .anim_en(anim_en), .anim_restart(anim_restart),
      .rom_address(romAddr1), .rom_q(romQ1),
      .pix_hit(pixHit1), .pix_index(pixIndex1),
      .anim_frame(animFrame1), .anim_done(animDone1)
   );

   // Animation frame implied by the number of enabled frame_start pulses
   function automatic int modelFrame(input bit oneShot);
      int steps = ticks / 6;
      if (oneShot) return (steps >= 7) ? 7 : steps;
      return steps % 8;
   endfunction

   function automatic bit modelDone(input bit oneShot);
      return oneShot && ((ticks / 6) >= 7);
   endfunction

   // Expected {hit, index} for a pixel under the current shadowed placement
   function automatic logic [2:0] modelPixel(input int x, input int y, input bit b,
                                             input int s, input bit oneShot);
      int size = 32 << s;
      int addr;
      logic [1:0] v;
      if (!(b && mEn && x >= mPx && x < mPx + size && y >= mPy && y < mPy + size))
         return 3'b000;
      addr = modelFrame(oneShot) * 1024 + ((y - mPy) >> s) * 32 + ((x - mPx) >> s);
      v = romMem[addr];
      if (v == 2'd0) return 3'b000;
      return {1'b1, v};
   endfunction

   // Drive one pixel coordinate
   task automatic applyStimulus(input int x, input int y, input bit b);
      DrawX = 10'(x);
      DrawY = 10'(y);
      blank = b;
   endtask

   // One-cycle frame_start pulse carrying a new placement; updates the model
   task automatic pulseFrame(input int px, input int py, input bit en, input bit restart);
      pos_x = 10'(px); pos_y = 10'(py); sprite_en = en;
      frame_start = 1'b1; anim_restart = restart;
      @(negedge vga_clk);
      frame_start = 1'b0; anim_restart = 1'b0;
      mPx = px; mPy = py; mEn = en;
      if (restart) ticks = 0;
      else if (anim_en) ticks++;
   endtask

   task automatic test_reset();
      reset_n = 1'b1; frame_start = 0; anim_en = 0; anim_restart = 0;
      sprite_en = 0; pos_x = 0; pos_y = 0;
      applyStimulus(0, 0, 0);
      #2 reset_n = 1'b0;
      #1;
      checks++; if (pixHit0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_pix_hit0: got %0d want 0", pixHit0); end
      checks++; if (pixIndex0 !== 2'd0) begin errors++; $display("[TB] FAIL reset_pix_index0: got %0d want 0", pixIndex0); end
      checks++; if (romAddr0 !== 13'd0) begin errors++; $display("[TB] FAIL reset_rom_address0: got %0d want 0", romAddr0); end
      checks++; if (animFrame0 !== 3'd0) begin errors++; $display("[TB] FAIL reset_anim_frame0: got %0d want 0", animFrame0); end
      checks++; if (animDone1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_anim_done1: got %0d want 0", animDone1); end
      checks++; if (pixHit1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_pix_hit1: got %0d want 0", pixHit1); end
      repeat (2) @(negedge vga_clk);
      reset_n = 1'b1;
      mPx = 0; mPy = 0; mEn = 0; ticks = 0;
      @(negedge vga_clk);
   endtask

   task automatic test_basic();
      romMem[0] = 2'd3; romMem[31] = 2'd1; romMem[992] = 2'd2;
      pulseFrame(100, 50, 1, 0);
      applyStimulus(100, 50, 1);
      @(negedge vga_clk);
      checks++; if (romAddr0 !== 13'd0) begin errors++; $display("[TB] FAIL basic_addr_origin: got %0d want 0", romAddr0); end
      repeat (2) @(negedge vga_clk);
      checks++; if (pixHit0 !== 1'b1) begin errors++; $display("[TB] FAIL basic_hit_origin: got %0d want 1", pixHit0); end
      checks++; if (pixIndex0 !== 2'd3) begin errors++; $display("[TB] FAIL basic_index_origin: got %0d want 3", pixIndex0); end
      applyStimulus(131, 50, 1);
      @(negedge vga_clk);
      checks++; if (romAddr0 !== 13'd31) begin errors++; $display("[TB] FAIL basic_addr_right: got %0d want 31", romAddr0); end
      repeat (2) @(negedge vga_clk);
      checks++; if (pixIndex0 !== 2'd1) begin errors++; $display("[TB] FAIL basic_index_right: got %0d want 1", pixIndex0); end
      applyStimulus(132, 50, 1);
      repeat (3) @(negedge vga_clk);
      checks++; if (pixHit0 !== 1'b0) begin errors++; $display("[TB] FAIL basic_hit_past_right: got %0d want 0", pixHit0); end
      applyStimulus(100, 81, 1);
      repeat (3) @(negedge vga_clk);
      checks++; if (pixIndex0 !== 2'd2) begin errors++; $display("[TB] FAIL basic_index_bottom: got %0d want 2", pixIndex0); end
      applyStimulus(100, 82, 1);
      repeat (3) @(negedge vga_clk);
      checks++; if (pixHit0 !== 1'b0) begin errors++; $display("[TB] FAIL basic_hit_past_bottom: got %0d want 0", pixHit0); end
      applyStimulus(99, 50, 1);
      repeat (3) @(negedge vga_clk);
      checks++; if (pixHit0 !== 1'b0) begin errors++; $display("[TB] FAIL basic_hit_left: got %0d want 0", pixHit0); end
   endtask

   task automatic test_scale();
      romMem[1023] = 2'd2; romMem[33] = 2'd1;
      pulseFrame(0, 0, 1, 0);
      applyStimulus(63, 63, 1);
      @(negedge vga_clk);
      checks++; if (romAddr1 !== 13'd1023) begin errors++; $display("[TB] FAIL scale_addr_corner: got %0d want 1023", romAddr1); end
      repeat (2) @(negedge vga_clk);
      checks++; if (pixHit1 !== 1'b1) begin errors++; $display("[TB] FAIL scale_hit_corner: got %0d want 1", pixHit1); end
      checks++; if (pixIndex1 !== 2'd2) begin errors++; $display("[TB] FAIL scale_index_corner: got %0d want 2", pixIndex1); end
      applyStimulus(64, 63, 1);
      repeat (3) @(negedge vga_clk);
      checks++; if (pixHit1 !== 1'b0) begin errors++; $display("[TB] FAIL scale_hit_past_edge: got %0d want 0", pixHit1); end
      applyStimulus(3, 2, 1);
      @(negedge vga_clk);
      checks++; if (romAddr1 !== 13'd33) begin errors++; $display("[TB] FAIL scale_addr_inner: got %0d want 33", romAddr1); end
   endtask

   task automatic test_transparent();
      romMem[5] = 2'd0; romMem[1] = 2'd2;
      pulseFrame(100, 50, 1, 0);
      applyStimulus(105, 50, 1);
      repeat (3) @(negedge vga_clk);
      checks++; if (pixHit0 !== 1'b0) begin errors++; $display("[TB] FAIL transp_hit: got %0d want 0", pixHit0); end
      checks++; if (pixIndex0 !== 2'd0) begin errors++; $display("[TB] FAIL transp_index: got %0d want 0", pixIndex0); end
      applyStimulus(101, 50, 1);
      repeat (3) @(negedge vga_clk);
      checks++; if (pixIndex0 !== 2'd2) begin errors++; $display("[TB] FAIL opaque_index: got %0d want 2", pixIndex0); end
      applyStimulus(101, 50, 0);
      repeat (3) @(negedge vga_clk);
      checks++; if (pixHit0 !== 1'b0) begin errors++; $display("[TB] FAIL blank_hit: got %0d want 0", pixHit0); end
      checks++; if (pixIndex0 !== 2'd0) begin errors++; $display("[TB] FAIL blank_index: got %0d want 0", pixIndex0); end
      pulseFrame(100, 50, 0, 0);
      applyStimulus(101, 50, 1);
      repeat (3) @(negedge vga_clk);
      checks++; if (pixHit0 !== 1'b0) begin errors++; $display("[TB] FAIL disabled_hit: got %0d want 0", pixHit0); end
   endtask

   task automatic test_shadow();
      romMem[0] = 2'd3;
      pulseFrame(100, 50, 1, 0);
      pos_x = 10'd300;
      applyStimulus(100, 50, 1);
      repeat (3) @(negedge vga_clk);
      checks++; if (pixHit0 !== 1'b1) begin errors++; $display("[TB] FAIL shadow_old_pos_hit: got %0d want 1", pixHit0); end
      applyStimulus(300, 50, 1);
      repeat (3) @(negedge vga_clk);
      checks++; if (pixHit0 !== 1'b0) begin errors++; $display("[TB] FAIL shadow_new_pos_early: got %0d want 0", pixHit0); end
      pulseFrame(300, 50, 1, 0);
      repeat (3) @(negedge vga_clk);
      checks++; if (pixIndex0 !== 2'd3) begin errors++; $display("[TB] FAIL shadow_new_pos_hit: got %0d want 3", pixIndex0); end
      applyStimulus(100, 50, 1);
      repeat (3) @(negedge vga_clk);
      checks++; if (pixHit0 !== 1'b0) begin errors++; $display("[TB] FAIL shadow_old_pos_gone: got %0d want 0", pixHit0); end
   endtask

   task automatic test_animation();
      applyStimulus(0, 0, 0);
      anim_en = 1'b1;
      anim_restart = 1'b1;
      @(negedge vga_clk);
      anim_restart = 1'b0;
      ticks = 0;
      for (int i = 0; i < 48; i++) begin
         pulseFrame(100, 50, 1, 0);
         checks++; if (animFrame0 !== 3'(modelFrame(0))) begin errors++; $display("[TB] FAIL anim_loop_frame step %0d: got %0d want %0d", i, animFrame0, modelFrame(0)); end
         checks++; if (animDone0 !== 1'b0) begin errors++; $display("[TB] FAIL anim_loop_done step %0d: got %0d want 0", i, animDone0); end
         checks++; if (animFrame1 !== 3'(modelFrame(1))) begin errors++; $display("[TB] FAIL anim_oneshot_frame step %0d: got %0d want %0d", i, animFrame1, modelFrame(1)); end
         checks++; if (animDone1 !== modelDone(1)) begin errors++; $display("[TB] FAIL anim_oneshot_done step %0d: got %0d want %0d", i, animDone1, modelDone(1)); end
      end
      checks++; if (animFrame0 !== 3'd0) begin errors++; $display("[TB] FAIL anim_loop_wrap: got %0d want 0", animFrame0); end
      checks++; if (animFrame1 !== 3'd7) begin errors++; $display("[TB] FAIL anim_oneshot_hold: got %0d want 7", animFrame1); end
      checks++; if (animDone1 !== 1'b1) begin errors++; $display("[TB] FAIL anim_oneshot_done_end: got %0d want 1", animDone1); end
      for (int i = 0; i < 9; i++) pulseFrame(100, 50, 1, 0);
      anim_en = 1'b0;
      for (int i = 0; i < 7; i++) pulseFrame(100, 50, 1, 0);
      checks++; if (animFrame0 !== 3'(modelFrame(0))) begin errors++; $display("[TB] FAIL anim_hold_disabled: got %0d want %0d", animFrame0, modelFrame(0)); end
      anim_en = 1'b1;
      pulseFrame(100, 50, 1, 1);
      checks++; if (animFrame1 !== 3'd0) begin errors++; $display("[TB] FAIL anim_restart_frame1: got %0d want 0", animFrame1); end
      checks++; if (animDone1 !== 1'b0) begin errors++; $display("[TB] FAIL anim_restart_done1: got %0d want 0", animDone1); end
      checks++; if (animFrame0 !== 3'd0) begin errors++; $display("[TB] FAIL anim_restart_frame0: got %0d want 0", animFrame0); end
      for (int i = 0; i < 6; i++) pulseFrame(100, 50, 1, 0);
      checks++; if (animFrame0 !== 3'(modelFrame(0))) begin errors++; $display("[TB] FAIL anim_after_restart: got %0d want %0d", animFrame0, modelFrame(0)); end
      anim_en = 1'b0;
   endtask

   task automatic test_random_pixels();
      logic [2:0] q0[$];
      logic [2:0] q1[$];
      logic [2:0] e0, e1;
      int px, py, x, y;
      bit en, b;
      for (int a = 0; a < 8192; a++) romMem[a] = 2'($urandom);
      for (int f = 0; f < 6; f++) begin
         px = int'($urandom_range(0, 1000));
         py = int'($urandom_range(0, 1000));
         en = ($urandom_range(0, 3) != 0);
         anim_en = 1'($urandom_range(0, 1));
         for (int c = 0; c < 120; c++) begin
            if (q0.size() >= 3) begin
               e0 = q0.pop_front(); e1 = q1.pop_front();
               checks++; if ({pixHit0, pixIndex0} !== e0) begin errors++; $display("[TB] FAIL rand_pixel0 frame %0d cyc %0d: got %0d want %0d", f, c, {pixHit0, pixIndex0}, e0); end
               checks++; if ({pixHit1, pixIndex1} !== e1) begin errors++; $display("[TB] FAIL rand_pixel1 frame %0d cyc %0d: got %0d want %0d", f, c, {pixHit1, pixIndex1}, e1); end
            end
            x = px + int'($urandom_range(0, 80)) - 8;
            y = py + int'($urandom_range(0, 80)) - 8;
            if (x < 0) x = 0;
            if (x > 1023) x = 1023;
            if (y < 0) y = 0;
            if (y > 1023) y = 1023;
            b = ($urandom_range(0, 7) != 0);
            applyStimulus(x, y, b);
            frame_start = (c == 0);
            if (c == 0) begin
               pos_x = 10'(px); pos_y = 10'(py); sprite_en = en;
            end
            q0.push_back(modelPixel(x, y, b, 0, 0));
            q1.push_back(modelPixel(x, y, b, 1, 1));
            if (c == 0) begin
               mPx = px; mPy = py; mEn = en;
               if (anim_en) ticks++;
            end
            @(negedge vga_clk);
         end
      end
      frame_start = 1'b0;
      applyStimulus(0, 0, 0);
      while (q0.size() > 0) begin
         e0 = q0.pop_front(); e1 = q1.pop_front();
         checks++; if ({pixHit0, pixIndex0} !== e0) begin errors++; $display("[TB] FAIL rand_drain0: got %0d want %0d", {pixHit0, pixIndex0}, e0); end
         checks++; if ({pixHit1, pixIndex1} !== e1) begin errors++; $display("[TB] FAIL rand_drain1: got %0d want %0d", {pixHit1, pixIndex1}, e1); end
         @(negedge vga_clk);
      end
      anim_en = 1'b0;
   endtask

   task automatic test_reset_midline();
      romMem[1024] = 2'd3;
      anim_en = 1'b1;
      pulseFrame(100, 50, 1, 1);
      for (int i = 0; i < 6; i++) pulseFrame(100, 50, 1, 0);
      applyStimulus(100, 50, 1);
      @(negedge vga_clk);
      checks++; if (romAddr0 !== 13'(modelFrame(0) * 1024)) begin errors++; $display("[TB] FAIL midline_addr_frame1: got %0d want %0d", romAddr0, modelFrame(0) * 1024); end
      repeat (2) @(negedge vga_clk);
      checks++; if ({pixHit0, pixIndex0} !== modelPixel(100, 50, 1, 0, 0)) begin errors++; $display("[TB] FAIL midline_pre_reset: got %0d want %0d", {pixHit0, pixIndex0}, modelPixel(100, 50, 1, 0, 0)); end
      @(posedge vga_clk);
      #2 reset_n = 1'b0;
      #1;
      checks++; if (pixHit0 !== 1'b0) begin errors++; $display("[TB] FAIL midline_pix_hit: got %0d want 0", pixHit0); end
      checks++; if (pixIndex0 !== 2'd0) begin errors++; $display("[TB] FAIL midline_pix_index: got %0d want 0", pixIndex0); end
      checks++; if (romAddr0 !== 13'd0) begin errors++; $display("[TB] FAIL midline_rom_address: got %0d want 0", romAddr0); end
      checks++; if (animFrame0 !== 3'd0) begin errors++; $display("[TB] FAIL midline_anim_frame0: got %0d want 0", animFrame0); end
      checks++; if (animFrame1 !== 3'd0) begin errors++; $display("[TB] FAIL midline_anim_frame1: got %0d want 0", animFrame1); end
      @(negedge vga_clk);
      reset_n = 1'b1;
      mPx = 0; mPy = 0; mEn = 0; ticks = 0;
      repeat (3) @(negedge vga_clk);
      checks++; if (pixHit0 !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_hit: got %0d want 0", pixHit0); end
      anim_en = 1'b0;
   endtask

   // Watchdog so the bench always ends even if a task stalls
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: time limit reached, tests did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   // Test sequence
   initial begin
      for (int a = 0; a < 8192; a++) romMem[a] = 2'd0;
      test_reset();
      test_basic();
      test_scale();
      test_transparent();
      test_shadow();
      test_animation();
      test_random_pixels();
      test_reset_midline();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
